// File: rtl/mdu_ctrl.sv
// HI/LO owner and multiply/divide sequencer for the execute stage.
// Define MDU_FAST_MUL_EN for a single-cycle multiplier; otherwise MUL is a 32-step shift-add.
module mdu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_valid,
  input  logic [5:0]  md_op,
  input  logic [31:0] md_src1,
  input  logic [31:0] md_src2,
  input  logic        md_ack,
  input  logic        md_cancel,
  output logic        md_done,
  output logic        hilo_busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [1:0]  dbg_state
);

  // Handshake: an op starts when md_valid & |md_op & ~md_cancel is seen in IDLE.
  // md_done rises once HI/LO hold the result and stays high until md_ack retires it.
  // md_cancel drops the op at any point; only a DONE-state commit survives it.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;

  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic [31:0] hi_q, hi_n, lo_q, lo_n;
  logic [31:0] work_hi, work_hi_n, work_lo, work_lo_n;
  logic [31:0] dvsr, dvsr_n, a_q, a_n;
  logic        neg_q, neg_q_n, neg_r, neg_r_n, b_zero, b_zero_n;
  logic        done_q, busy_q;

  logic        start, sgn_start;
  logic [31:0] abs_a, abs_b;

  assign start     = md_valid & (|md_op) & ~md_cancel;
  assign sgn_start = md_op[0] | md_op[2];
  assign abs_a     = (sgn_start & md_src1[31]) ? -md_src1 : md_src1;
  assign abs_b     = (sgn_start & md_src2[31]) ? -md_src2 : md_src2;

  // One restoring-division step: remainder in work_hi, dividend shifting out of work_lo.
  logic [32:0] div_tmp, div_sub;
  logic        div_ge;
  logic [31:0] div_rem, div_quo, div_q_fix, div_r_fix;

  assign div_tmp   = {work_hi, work_lo[31]};
  assign div_sub   = div_tmp - {1'b0, dvsr};
  assign div_ge    = (div_tmp >= {1'b0, dvsr});
  assign div_rem   = div_ge ? div_sub[31:0] : div_tmp[31:0];
  assign div_quo   = {work_lo[30:0], div_ge};
  assign div_q_fix = neg_q ? -div_quo : div_quo;
  assign div_r_fix = neg_r ? -div_rem : div_rem;

`ifdef MDU_FAST_MUL_EN
  // 33x33 signed product; the low 64 bits are right for both mult and multu.
  logic [31:0]        b_q, b_n;
  logic               sgn_q, sgn_n;
  logic signed [32:0] mul_a, mul_b;
  logic signed [65:0] prod_fast;

  assign mul_a     = {sgn_q & a_q[31], a_q};
  assign mul_b     = {sgn_q & b_q[31], b_q};
  assign prod_fast = mul_a * mul_b;
`else
  // One shift-add step: multiplicand in dvsr, multiplier shifting out of work_lo.
  logic [32:0] mul_sum;
  logic [31:0] mul_hi, mul_lo;
  logic [63:0] prod, prod_fix;

  assign mul_sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, dvsr} : 33'd0);
  assign mul_hi   = mul_sum[32:1];
  assign mul_lo   = {mul_sum[0], work_lo[31:1]};
  assign prod     = {mul_hi, mul_lo};
  assign prod_fix = neg_q ? -prod : prod;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hi_n      = hi_q;
    lo_n      = lo_q;
    work_hi_n = work_hi;
    work_lo_n = work_lo;
    dvsr_n    = dvsr;
    a_n       = a_q;
    neg_q_n   = neg_q;
    neg_r_n   = neg_r;
    b_zero_n  = b_zero;
`ifdef MDU_FAST_MUL_EN
    b_n       = b_q;
    sgn_n     = sgn_q;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          cnt_n     = 6'd0;
          work_hi_n = 32'd0;
          work_lo_n = abs_a;
          dvsr_n    = abs_b;
          a_n       = md_src1;
          neg_q_n   = sgn_start & (md_src1[31] ^ md_src2[31]);
          neg_r_n   = sgn_start & md_src1[31];
          b_zero_n  = (md_src2 == 32'd0);
`ifdef MDU_FAST_MUL_EN
          b_n       = md_src2;
          sgn_n     = sgn_start;
`endif
          if (md_op[4]) begin
            hi_n    = md_src1;
            state_n = S_DONE;
          end else if (md_op[5]) begin
            lo_n    = md_src1;
            state_n = S_DONE;
          end else if (md_op[0] | md_op[1]) begin
            state_n = S_MUL;
          end else begin
            state_n = S_DIV;
          end
        end
      end
      S_MUL: begin
`ifdef MDU_FAST_MUL_EN
        hi_n    = prod_fast[63:32];
        lo_n    = prod_fast[31:0];
        state_n = S_DONE;
`else
        work_hi_n = mul_hi;
        work_lo_n = mul_lo;
        cnt_n     = cnt + 6'd1;
        if (cnt == 6'd31) begin
          hi_n    = prod_fix[63:32];
          lo_n    = prod_fix[31:0];
          state_n = S_DONE;
        end
`endif
      end
      S_DIV: begin
        work_hi_n = div_rem;
        work_lo_n = div_quo;
        cnt_n     = cnt + 6'd1;
        if (cnt == 6'd31) begin
          // A zero divisor reports all-ones quotient and the raw dividend as remainder.
          hi_n    = b_zero ? a_q : div_r_fix;
          lo_n    = b_zero ? 32'hFFFF_FFFF : div_q_fix;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (md_ack) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (md_cancel) begin
      state_n = S_IDLE;
      hi_n    = hi_q;
      lo_n    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 6'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      work_hi <= 32'd0;
      work_lo <= 32'd0;
      dvsr    <= 32'd0;
      a_q     <= 32'd0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      b_zero  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MDU_FAST_MUL_EN
      b_q     <= 32'd0;
      sgn_q   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
      work_hi <= work_hi_n;
      work_lo <= work_lo_n;
      dvsr    <= dvsr_n;
      a_q     <= a_n;
      neg_q   <= neg_q_n;
      neg_r   <= neg_r_n;
      b_zero  <= b_zero_n;
      done_q  <= (state_n == S_DONE);
      busy_q  <= (state_n != S_IDLE);
`ifdef MDU_FAST_MUL_EN
      b_q     <= b_n;
      sgn_q   <= sgn_n;
`endif
    end
  end

  assign md_done   = done_q;
  assign hilo_busy = busy_q;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign dbg_state = state;

endmodule
